// File: rtl/line_fetcher.sv
// line_fetcher: PSRAM-domain producer for the display line buffer.
//
// Each accepted line request is turned into a sequence of fixed-length PSRAM
// read bursts covering one visible line. Every returned RGB565 beat is widened
// to RGB888 and written into the line buffer, one cycle after the beat, at
// ascending pixel addresses.
//
// Build option: define LINE_FETCH_OVF_CNT_EN to get a saturating counter of
// overrun pulses on ovf_count. Without it ovf_count is tied to zero.
//
// Ports:
//   clk_psram      PSRAM-domain clock (only clock)
//   rst            synchronous active-high reset
//   line_req       one-cycle line request pulse
//   line_idx       line index, sampled with line_req
//   mem_cmd_valid  burst read command valid
//   mem_cmd_ready  controller accepts command on valid&ready
//   mem_cmd_addr   burst start word address
//   mem_cmd_len    burst length, constant BURST_LEN
//   mem_rd_valid   read data beat valid
//   mem_rd_data    RGB565 beat
//   wr_en          line buffer write strobe
//   wr_addr        pixel index within the line
//   wr_data        RGB888 pixel
//   busy           high while not IDLE
//   overrun        one-cycle pulse when a pending request is overwritten
//   ovf_count      overrun counter (zero unless LINE_FETCH_OVF_CNT_EN)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a pending request
// CMD   | burst read command presented, waiting for mem_cmd_ready
// DATA  | collecting BURST_LEN beats of the current burst

module line_fetcher #(
  parameter int              H_ACTIVE  = 800,
  parameter int              V_ACTIVE  = 480,
  parameter int              BURST_LEN = 32,
  parameter int              ADDR_W    = 22,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input  logic              clk_psram,
  input  logic              rst,
  input  logic              line_req,
  input  logic [9:0]        line_idx,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [7:0]        mem_cmd_len,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic              wr_en,
  output logic [9:0]        wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       ovf_count
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam logic [10:0] V_LIMIT    = 11'(V_ACTIVE);
  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [9:0]  LAST_BURST = 10'(H_ACTIVE / BURST_LEN - 1);

  state_t      state;
  logic        pend;
  logic [9:0]  pend_idx;
  logic [9:0]  burst;
  logic [7:0]  beat;
  logic [9:0]  pix;
  logic        consume;
  logic        req_ok;
  logic [ADDR_W-1:0] line_base;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  assign mem_cmd_len = 8'(BURST_LEN);
  assign busy        = (state != IDLE);
  assign consume     = (state == IDLE) && pend;
  assign req_ok      = line_req && ({1'b0, line_idx} < V_LIMIT);

  // Start address of the pending line; truncation to ADDR_W gives the wrap.
  assign line_base = FB_BASE + ADDR_W'(pend_idx) * ADDR_W'(H_ACTIVE);

  always_ff @(posedge clk_psram) begin
    if (rst) begin
      state         <= IDLE;
      pend          <= 1'b0;
      pend_idx      <= '0;
      burst         <= '0;
      beat          <= '0;
      pix           <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_addr  <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      overrun       <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      overrun <= 1'b0;

      // A new request wins over consumption, so a request arriving while IDLE
      // takes the pending slot just vacated without counting as an overrun.
      if (req_ok) begin
        pend     <= 1'b1;
        pend_idx <= line_idx;
        if (pend && !consume) overrun <= 1'b1;
      end else if (consume) begin
        pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pend) begin
            burst         <= '0;
            pix           <= '0;
            mem_cmd_addr  <= line_base;
            mem_cmd_valid <= 1'b1;
            state         <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            beat          <= '0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (mem_rd_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= pix;
            wr_data <= rgb565_to_888(mem_rd_data);
            pix     <= pix + 10'd1;
            beat    <= beat + 8'd1;
            if (beat == LAST_BEAT) begin
              if (burst == LAST_BURST) begin
                state <= IDLE;
              end else begin
                burst         <= burst + 10'd1;
                mem_cmd_addr  <= mem_cmd_addr + ADDR_W'(BURST_LEN);
                mem_cmd_valid <= 1'b1;
                state         <= CMD;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_FETCH_OVF_CNT_EN
  always_ff @(posedge clk_psram) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (overrun && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_line_fetcher.sv
// Testbench for line_fetcher: random command stalls and beat gaps, checked
// against a pixel-level reference of the framebuffer contents.

module tb_line_fetcher;

  localparam int          H   = 800;
  localparam int          B   = 32;
  localparam int unsigned FB  = 32'h003F_FF00;
  localparam int unsigned AMASK = 32'h003F_FFFF;

  logic        clk_psram = 1'b0;
  logic        rst;
  logic        line_req;
  logic [9:0]  line_idx;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic [21:0] mem_cmd_addr;
  logic [7:0]  mem_cmd_len;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        overrun;
  logic [15:0] ovf_count;

  always #5 clk_psram = ~clk_psram;

  line_fetcher #(
    .H_ACTIVE(H), .V_ACTIVE(480), .BURST_LEN(B), .ADDR_W(22), .FB_BASE(22'h3FFF00)
  ) dut (
    .clk_psram(clk_psram), .rst(rst), .line_req(line_req), .line_idx(line_idx),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .overrun(overrun), .ovf_count(ovf_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
  endtask

  // Reference framebuffer: a hash of the word address plus a few fixed pixels.
  logic [15:0] ovr [int unsigned];

  function automatic int unsigned addr_of(input int unsigned line, input int unsigned p);
    return (FB + line * H + p) & AMASK;
  endfunction

  function automatic logic [15:0] mem_word(input int unsigned a);
    int unsigned m;
    m = a & AMASK;
    if (ovr.exists(m)) return ovr[m];
    return 16'((m * 32'h9E37_79B1) >> 11);
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p);
    int unsigned r, g, b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 24'((r << 16) | (g << 8) | b);
  endfunction

  // Expected sequence of fetched lines, consumed separately by the command
  // checker and the write checker.
  int          exp_lines[$];
  int          w_ptr = 0, w_pix = 0, c_ptr = 0, c_b = 0;
  int          lines_done = 0, n_cmd = 0, n_wr = 0, ovr_seen = 0;
  logic [23:0] cap[4];
  bit          stall_en = 0;

  // Memory responder and output monitor, all on the falling edge.
  initial begin
    int unsigned beat_addr;
    int          beats_left;
    bit          prev_beat, hold_v;
    logic [21:0] hold_addr;
    int          l;
    beats_left = 0; prev_beat = 0; hold_v = 0; hold_addr = '0; beat_addr = 0;
    mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    forever begin
      @(negedge clk_psram);
      check("wr_latency", wr_en, prev_beat);
      if (overrun) ovr_seen++;
      if (wr_en) begin
        if (w_ptr < exp_lines.size()) begin
          l = exp_lines[w_ptr];
          check("wr_addr", wr_addr, w_pix);
          check("wr_data", wr_data, expand(mem_word(addr_of(l, w_pix))));
          if (l == 3 && w_pix < 4) cap[w_pix] = wr_data;
          w_pix++;
          n_wr++;
          if (w_pix == H) begin
            check("busy_end", busy, 0);
            w_pix = 0;
            w_ptr++;
            lines_done++;
          end
        end else begin
          check("wr_unexpected", w_ptr, exp_lines.size());
        end
      end

      prev_beat    = 0;
      mem_rd_valid = 1'b0;
      if (rst) begin
        beats_left = 0;
        hold_v     = 0;
      end else begin
        if (beats_left > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_word(beat_addr);
          beat_addr++;
          beats_left--;
          prev_beat = 1;
        end
        mem_cmd_ready = !stall_en || ($urandom_range(0, 2) != 0);
        if (mem_cmd_valid) begin
          check("one_outstanding", beats_left, 0);
          if (hold_v) check("cmd_hold", mem_cmd_addr, hold_addr);
          if (mem_cmd_ready) begin
            hold_v = 0;
            if (c_ptr < exp_lines.size())
              check("cmd_addr", mem_cmd_addr, addr_of(exp_lines[c_ptr], c_b * B));
            else
              check("cmd_unexpected", c_ptr, exp_lines.size());
            c_b++;
            if (c_b == H / B) begin c_b = 0; c_ptr++; end
            n_cmd++;
            beats_left = B;
            beat_addr  = mem_cmd_addr;
          end else begin
            hold_v    = 1;
            hold_addr = mem_cmd_addr;
          end
        end else begin
          hold_v = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_psram);
    #2;
  endtask

  task automatic req(input int idx);
    line_idx = 10'(idx);
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_lines(input int n);
    int target, cyc;
    target = lines_done + n;
    cyc = 0;
    while (lines_done < target && cyc < 6000 * n) begin
      tick();
      cyc++;
    end
    check("line_done", lines_done, target);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_valid"}, mem_cmd_valid, 0);
    check({tag, "_cmd_addr"}, mem_cmd_addr, 0);
    check({tag, "_cmd_len"}, mem_cmd_len, B);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_ovf"}, ovf_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, o0, r, cyc, exp_ovf;
`ifdef LINE_FETCH_OVF_CNT_EN
    exp_ovf = 2;
`else
    exp_ovf = 0;
`endif
    ovr[addr_of(3, 0)] = 16'hF800;
    ovr[addr_of(3, 1)] = 16'h07E0;
    ovr[addr_of(3, 2)] = 16'h0821;
    ovr[addr_of(3, 3)] = 16'h0841;

    rst = 1'b1; line_req = 1'b0; line_idx = '0;
    repeat (3) tick();
    @(negedge clk_psram);
    check_zero_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Line 0, no stalls, continuous beats.
    c0 = n_cmd; w0 = n_wr;
    exp_lines.push_back(0);
    req(0);
    wait_lines(1);
    check("cmds_line0", n_cmd - c0, H / B);
    check("writes_line0", n_wr - w0, H);

    // Last line with the address wrapping past 2^22, under stalls and gaps.
    stall_en = 1;
    c0 = n_cmd;
    exp_lines.push_back(479);
    req(479);
    wait_lines(1);
    check("cmds_line479", n_cmd - c0, H / B);

    // Known pixels for the colour expansion.
    exp_lines.push_back(3);
    req(3);
    wait_lines(1);
    check("px_red", cap[0], 24'hFF0000);
    check("px_green", cap[1], 24'h00FF00);
    check("px_low", cap[2], 24'h080408);
    check("px_mix", cap[3], 24'h080808);

    r = $urandom_range(0, 479);
    exp_lines.push_back(r);
    req(r);
    wait_lines(1);

    // Overrun: 5, 6, 7 arrive while line 4 is in flight; only 7 survives.
    o0 = ovr_seen;
    exp_lines.push_back(4);
    req(4);
    repeat (5) tick();
    check("busy_line4", busy, 1);
    req(5);
    repeat (3) tick();
    req(6);
    repeat (3) tick();
    exp_lines.push_back(7);
    req(7);
    wait_lines(2);
    check("overruns", ovr_seen - o0, 2);
    check("ovf_count", ovf_count, exp_ovf);

    // Reset about 100 beats into a line with another request pending.
    exp_lines.push_back(2);
    req(2);
    cyc = 0;
    while (w_pix < 100 && cyc < 4000) begin tick(); cyc++; end
    check("reach_beat100", w_pix >= 100, 1);
    req(9);
    rst = 1'b1;
    tick();
    @(negedge clk_psram);
    check_zero_outputs("midrst");
    tick();
    exp_lines.delete();
    w_ptr = 0; w_pix = 0; c_ptr = 0; c_b = 0;
    rst = 1'b0;
    c0 = n_cmd;
    repeat (20) tick();
    check("pend_cleared", n_cmd, c0);
    check("idle_after_rst", busy, 0);
    exp_lines.push_back(1);
    req(1);
    wait_lines(1);
    check("cmds_line1", n_cmd - c0, H / B);

    // Out-of-range line is dropped silently.
    c0 = n_cmd; o0 = ovr_seen;
    req(480);
    repeat (30) tick();
    check("oor_no_cmd", n_cmd, c0);
    check("oor_no_overrun", ovr_seen, o0);
    check("oor_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
